// File: rtl/expr_sig_collector.sv
// Collects 90-bit expression results into a 32-bit Galois MISR signature, counts
// accepted vectors, and reports done plus a golden-signature compare after NUM_VECS.
module expr_sig_collector #(
  parameter int          NUM_VECS = 256,
  parameter logic [31:0] SEED     = 32'hFFFFFFFF,
  parameter logic [31:0] POLY     = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        y_valid,
  output logic        y_ready,
  input  logic [89:0] y_in,
  input  logic [31:0] expect_sig,
  output logic [31:0] sig,
  output logic [15:0] vec_count,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(NUM_VECS - 1);

  // Handshake: a vector transfers on a rising edge where y_valid and y_ready are
  // both high; y_ready depends only on state, never on y_valid.
  state_t      state, state_next;
  logic [31:0] sig_next;
  logic [15:0] count_next;
  logic        pass_next;
  logic        accept;
  logic [31:0] fold;
  logic [31:0] misr;

  assign y_ready = (state == RUN);
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign accept  = y_valid & y_ready;

  assign fold = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
  assign misr = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;

  always_comb begin
    state_next = state;
    sig_next   = sig;
    count_next = vec_count;
    pass_next  = pass;
    if (clear) begin
      state_next = IDLE;
      sig_next   = SEED;
      count_next = 16'd0;
      pass_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = RUN;
            sig_next   = SEED;
            count_next = 16'd0;
            pass_next  = 1'b0;
          end
        end
        RUN: begin
          // y_in and expect_sig only reach state through this branch
          if (accept) begin
            sig_next   = misr;
            count_next = vec_count + 16'd1;
            if (vec_count == LAST) begin
              state_next = DONE;
              pass_next  = (misr == expect_sig);
            end
          end
        end
        DONE: begin
          if (start) begin
            state_next = RUN;
            sig_next   = SEED;
            count_next = 16'd0;
            pass_next  = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          sig_next   = SEED;
          count_next = 16'd0;
          pass_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sig       <= SEED;
      vec_count <= 16'd0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      sig       <= sig_next;
      vec_count <= count_next;
      pass      <= pass_next;
    end
  end

endmodule
